irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_if.sv | 25 ++
 rtl/irq_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl_if.sv
// Interrupt controller bus: raw lines, mask and eret go into the controller;
// the request pulse, cause, busy flag and pending status come back out.
interface irq_ctrl_if #(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0] irq_raw;
    logic [N_SRC-1:0] irq_mask;
    logic             eret;
    logic             ir_in;
    logic [2:0]       irq_cause;
    logic             irq_busy;
    logic [N_SRC-1:0] irq_pending;

    // Pipeline / exception-stage side
    modport master (
        output irq_raw, irq_mask, eret,
        input  ir_in, irq_cause, irq_busy, irq_pending
    );

    // Interrupt controller side
    modport slave (
        input  irq_raw, irq_mask, eret,
        output ir_in, irq_cause, irq_busy, irq_pending
    );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronizes N_SRC raw interrupt lines, latches rising edges into
// pending bits and dispatches the lowest-index enabled one to the exception
// stage as a one-cycle ir_in pulse, then waits for eret.
// Optional macro IRQ_DEBOUNCE_EN adds a per-source 16-bit debounce counter
// (threshold DB_CYCLES) between the synchronizer and the edge detector.
// Reset rst is asynchronous and active-low.
module irq_ctrl #(
    parameter int          N_SRC     = 4,
    parameter logic [15:0] DB_CYCLES = 16'd50000
) (
    input  logic      clk,
    input  logic      rst,
    irq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Illegal parameter values elaborate a named marker scope that shows up in
    // the hierarchy of any tool report.
    if (N_SRC < 2 || N_SRC > 8 || DB_CYCLES < 16'd2) begin : g_param_out_of_range
    end

    logic [N_SRC-1:0] sync1_q;
    logic [N_SRC-1:0] sync2_q;
    logic [N_SRC-1:0] level;
    logic [N_SRC-1:0] hist_q;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pending_q;
    logic [N_SRC-1:0] pending_d;
    logic [N_SRC-1:0] clr_vec;
    logic [N_SRC-1:0] eligible;
    logic [2:0]       settle_q;
    logic             settled;
    logic [2:0]       first_idx;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] cause_q;
    logic [2:0] cause_d;
    logic       ir_in_q;
    logic       ir_in_d;
    logic       busy_q;
    logic       busy_d;

    // Two-flop synchronizer on every raw line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.irq_raw;
            sync2_q <= sync1_q;
        end
    end

    // Start-up settling: edges are ignored until the synchronizer (and the
    // debouncer, when built) hold a real sample, so a line already high at
    // reset release is taken as the initial level rather than as an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            settle_q <= 3'd0;
        end else if (settle_q != 3'd4) begin
            settle_q <= settle_q + 3'd1;
        end
    end

    assign settled = (settle_q == 3'd4);

`ifdef IRQ_DEBOUNCE_EN
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_db
        logic [15:0] cnt_q;
        logic        db_q;

        // Debounce: follow the synchronized level only after it has differed
        // for DB_CYCLES consecutive cycles; before settling, copy it directly.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
                db_q  <= 1'b0;
            end else if (!settled) begin
                cnt_q <= '0;
                db_q  <= sync2_q[gi];
            end else if (sync2_q[gi] != db_q) begin
                if (cnt_q == DB_CYCLES - 16'd1) begin
                    cnt_q <= '0;
                    db_q  <= sync2_q[gi];
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end else begin
                cnt_q <= '0;
            end
        end

        assign level[gi] = db_q;
    end
`else
    assign level = sync2_q;
`endif

    // Edge history of the conditioned level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= level;
        end
    end

    assign rise      = level & ~hist_q & {N_SRC{settled}};
    // A new edge wins over the dispatch clear of the same bit.
    assign pending_d = (pending_q & ~clr_vec) | rise;
    assign eligible  = pending_q & bus.irq_mask;

    // Pending bits: set by edges, cleared only by dispatch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Fixed priority: lowest eligible index
    always_comb begin
        first_idx = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                first_idx = 3'(i);
            end
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cause_q <= 3'd0;
            ir_in_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            ir_in_q <= ir_in_d;
            busy_q  <= busy_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (|eligible) state_d = ST_REQ;
            ST_REQ:     state_d = ST_SERVICE;
            ST_SERVICE: if (bus.eret) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: cause latch, request pulse, busy flag, pending clear
    always_comb begin
        cause_d = cause_q;
        ir_in_d = 1'b0;
        busy_d  = busy_q;
        clr_vec = '0;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) cause_d = first_idx;
            end
            ST_REQ: begin
                ir_in_d = 1'b1;
                busy_d  = 1'b1;
                clr_vec = {{(N_SRC - 1){1'b0}}, 1'b1} << cause_q;
            end
            ST_SERVICE: begin
                if (bus.eret) busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.ir_in       = ir_in_q;
    assign bus.irq_cause   = cause_q;
    assign bus.irq_busy    = busy_q;
    assign bus.irq_pending = pending_q;

endmodule
